// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU divide scheduler.
// The datapath is IEEE-754 single precision, so the helpers assume 32-bit operands.
package fpu_sched_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Magnitude of the infinity returned on a zero divisor; the sign is prepended by the caller.
  localparam logic [30:0] ZDIV_INF_MAG = {8'hFF, 23'd0};

  function automatic logic is_zero(input logic [31:0] operand);
    return (operand[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/FloatingDivision.sv
// Combinational IEEE-754 single-precision divider; denormal inputs are flushed to zero,
// the quotient is rounded half-up from one guard bit.
module FloatingDivision (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero_division
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic               w_sign;
  logic [7:0]         w_ea, w_eb;
  logic [22:0]        w_ma, w_mb;
  logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [48:0]        w_num;
  logic [23:0]        w_den;
  logic [25:0]        w_q;
  logic signed [9:0]  w_exp;
  logic [22:0]        w_frac;
  logic               w_guard;
  logic [30:0]        w_mag;

  assign w_sign   = i_a[31] ^ i_b[31];
  assign w_ea     = i_a[30:23];
  assign w_eb     = i_b[30:23];
  assign w_ma     = i_a[22:0];
  assign w_mb     = i_b[22:0];
  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 23'd0);
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);

  // Quotient of the two significands scaled by 2^25: lies in (2^24, 2^26).
  assign w_num = {1'b1, w_ma, 25'd0};
  assign w_den = {1'b1, w_mb};
  assign w_q   = 26'(w_num / {25'd0, w_den});

  assign w_exp   = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                 + (w_q[25] ? 10'sd127 : 10'sd126);
  assign w_frac  = w_q[25] ? w_q[24:2] : w_q[23:1];
  assign w_guard = w_q[25] ? w_q[1]    : w_q[0];
  assign w_mag   = {w_exp[7:0], w_frac} + {30'd0, w_guard};

  assign o_zero_division = (i_b[30:0] == 31'd0);

  always_comb begin
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      o_result = QNAN;
    end else if (w_a_inf || w_b_zero) begin
      o_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_inf || w_a_zero) begin
      o_result = {w_sign, 31'd0};
    end else if (w_exp >= 10'sd255) begin
      o_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_exp <= 10'sd0) begin
      o_result = {w_sign, 31'd0};
    end else begin
      o_result = {w_sign, w_mag};
    end
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after i_ptr, wrapping.
module fpu_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W:0] w_sum;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
      if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
      end
      if (i_en && !w_found && i_req[w_sum[ID_W-1:0]]) begin
        w_found                  = 1'b1;
        o_grant[w_sum[ID_W-1:0]] = 1'b1;
        o_idx                    = w_sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_div_scheduler.sv
// Round-robin scheduler sharing one combinational divider treated as a DIV_CYCLES multicycle path.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; ready never waits on nothing but state and arbitration.
module fpu_div_scheduler
  import fpu_sched_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEF,
  parameter  int NUM_REQ    = 4,
  parameter  int DIV_CYCLES = 3,
  parameter  int CNT_W      = 16,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int WC_W       = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [XLEN-1:0]         resp_result,
  output logic                    resp_zero_div,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  sched_state_e     r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [WC_W-1:0]  r_cnt;
  logic [XLEN-1:0]  r_a, r_b;
  logic [ID_W-1:0]  r_id;
  logic             r_resp_valid;
  logic [ID_W-1:0]  r_resp_id;
  logic [XLEN-1:0]  r_resp_result;
  logic             r_resp_zd;
  logic [CNT_W-1:0] r_op_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_arb_en;
  logic               w_accept;
  logic [XLEN-1:0]    w_sel_a, w_sel_b;
  logic [XLEN-1:0]    w_div_result;
  logic               w_div_zd;

  // Ready is masked during reset so no grant leaks out while the FSM is held.
  assign w_arb_en = (r_state == IDLE) && !rst;

  fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  FloatingDivision u_div (
    .i_a             (r_a),
    .i_b             (r_b),
    .o_result        (w_div_result),
    .o_zero_division (w_div_zd)
  );

  assign w_accept = |w_grant;
  assign w_sel_a  = req_a[w_gidx*XLEN +: XLEN];
  assign w_sel_b  = req_b[w_gidx*XLEN +: XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_id          <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
      r_resp_zd     <= 1'b0;
      r_op_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_id  <= w_gidx;
            r_ptr <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
            if (is_zero(w_sel_b)) begin
              r_resp_result <= {w_sel_a[XLEN-1] ^ w_sel_b[XLEN-1], ZDIV_INF_MAG};
              r_resp_zd     <= 1'b1;
              r_resp_id     <= w_gidx;
              r_resp_valid  <= 1'b1;
              r_state       <= RESP;
            end else begin
              r_cnt   <= WC_W'(DIV_CYCLES - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Operands have been stable for DIV_CYCLES clocks when the count reaches zero.
          if (r_cnt == '0) begin
            r_resp_result <= w_div_result;
            r_resp_zd     <= w_div_zd;
            r_resp_id     <= r_id;
            r_resp_valid  <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_cnt <= r_cnt - WC_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_op_count   <= r_op_count + CNT_W'(1);
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready     = w_grant;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_result   = r_resp_result;
  assign resp_zero_div = r_resp_zd;
  assign busy          = (r_state != IDLE);
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_fpu_div_scheduler.sv
// Self-checking bench for fpu_div_scheduler; a second instance with CNT_W=2 shares all inputs
// so its op_count shows the wrap sequence.
module tb_fpu_div_scheduler;

  localparam int XLEN       = 32;
  localparam int NUM_REQ    = 4;
  localparam int DIV_CYCLES = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready, req_ready_c2;
  logic [NUM_REQ*XLEN-1:0] req_a, req_b;
  logic                    resp_valid, resp_valid_c2;
  logic                    resp_ready;
  logic [1:0]              resp_id, resp_id_c2;
  logic [31:0]             resp_result, resp_result_c2;
  logic                    resp_zero_div, resp_zero_div_c2;
  logic                    busy, busy_c2;
  logic [15:0]             op_count;
  logic [1:0]              op_count_c2;

  fpu_div_scheduler #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .DIV_CYCLES(DIV_CYCLES), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_zero_div(resp_zero_div),
    .busy(busy), .op_count(op_count)
  );

  fpu_div_scheduler #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .DIV_CYCLES(DIV_CYCLES), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_c2),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid_c2), .resp_ready(resp_ready),
    .resp_id(resp_id_c2), .resp_result(resp_result_c2), .resp_zero_div(resp_zero_div_c2),
    .busy(busy_c2), .op_count(op_count_c2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [35:0] exp_q[$];      // {approx, zero_div, id, result}
  logic [1:0]  exp_gnt_q[$];  // predicted grant order
  logic [15:0] exp_count = '0;

  logic [31:0] tab_res [NUM_REQ];
  logic        tab_zd  [NUM_REQ];
  logic        tab_apx [NUM_REQ];
  int          rem     [NUM_REQ];

  logic [31:0] vec_a [4] = '{32'h41000000, 32'h40C00000, 32'h3F800000, 32'hC1100000};
  logic [31:0] vec_b [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40400000};
  logic [31:0] vec_q [4] = '{32'h40800000, 32'h40000000, 32'h3E800000, 32'hC0400000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [35:0] m_e;
  logic [31:0] m_r;
  logic [3:0]  m_hs;
  logic [1:0]  m_g;
  int          m_d;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  bit          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (busy) check_val("ready_busy", {28'd0, req_ready}, 32'd0);
      if (req_ready != 4'd0) check_val("ready_onehot", $countones(req_ready), 32'd1);
      m_hs = req_valid & req_ready;
      if (m_hs != 4'd0) begin
        if (exp_gnt_q.size() == 0) begin
          check_val("gnt_extra", {28'd0, m_hs}, 32'd0);
        end else begin
          m_g = exp_gnt_q.pop_front();
          check_val("gnt_order", {28'd0, m_hs}, 32'd1 << m_g);
          exp_q.push_back({tab_apx[m_g], tab_zd[m_g], m_g, tab_res[m_g]});
          acc_cyc = cyc;
          exp_lat = tab_zd[m_g] ? 1 : DIV_CYCLES + 1;
        end
      end
      if (resp_valid && !prev_valid) check_val("latency", cyc - acc_cyc, exp_lat);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check_val("resp_extra", {31'd0, resp_valid}, 32'd0);
        end else begin
          m_e = exp_q[0];
          m_r = resp_result;
          m_d = $signed(resp_result) - $signed(m_e[31:0]);
          if (m_e[35] && m_d >= -1 && m_d <= 1) m_r = m_e[31:0];
          check_val("resp_id", {30'd0, resp_id}, {30'd0, m_e[33:32]});
          check_val("resp_result", m_r, m_e[31:0]);
          check_val("resp_zdiv", {31'd0, resp_zero_div}, {31'd0, m_e[34]});
          check_val("count_hold", {16'd0, op_count}, {16'd0, exp_count});
          check_val("count_wrap", {30'd0, op_count_c2}, {30'd0, exp_count[1:0]});
          if (resp_ready) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 16'd1;
          end
        end
      end
      prev_valid = resp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic zd, input logic apx, input int n);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    tab_res[i] = res;
    tab_zd[i]  = zd;
    tab_apx[i] = apx;
    rem[i]     = n;
    req_valid[i] = (n > 0);
  endtask

  // Holds requests until each has been accepted rem[i] times; operands are scrambled afterwards.
  task automatic serve(input int budget);
    int k = 0;
    logic [3:0] hs;
    while (req_valid != 4'd0 && k < budget) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin
            req_valid[i] = 1'b0;
            req_a[i*XLEN +: XLEN] = $urandom;
            req_b[i*XLEN +: XLEN] = $urandom;
          end
        end
      end
      k++;
    end
    if (req_valid != 4'd0) check_val("serve_timeout", {28'd0, req_valid}, 32'd0);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_val("drain_empty", exp_q.size(), 32'd0);
    check_val("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    check_val({tag, "_id"}, {30'd0, resp_id}, 32'd0);
    check_val({tag, "_result"}, resp_result, 32'd0);
    check_val({tag, "_zdiv"}, {31'd0, resp_zero_div}, 32'd0);
    check_val({tag, "_count"}, {16'd0, op_count}, 32'd0);
    check_val({tag, "_count_c2"}, {30'd0, op_count_c2}, 32'd0);
    check_val({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int v;
    logic [31:0] a, b;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin with all four requesters held valid.
    exp_gnt_q.push_back(2'd0);
    exp_gnt_q.push_back(2'd1);
    exp_gnt_q.push_back(2'd2);
    exp_gnt_q.push_back(2'd3);
    exp_gnt_q.push_back(2'd0);
    set_op(0, 32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 2);
    set_op(1, 32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0, 1'b0, 1);
    set_op(2, 32'hC1100000, 32'h40400000, 32'hC0400000, 1'b0, 1'b0, 1);
    set_op(3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b1, 1);
    serve(300);
    drain(100);
    check_val("rr_count", {16'd0, op_count}, 32'd5);
    check_val("rr_count_c2", {30'd0, op_count_c2}, 32'd1);

    // Basic exact divide from requester 1.
    exp_gnt_q.push_back(2'd1);
    set_op(1, 32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 1);
    serve(50);
    drain(50);
    check_val("basic_count", {16'd0, op_count}, 32'd6);

    // Zero divisor, both signs.
    exp_gnt_q.push_back(2'd0);
    set_op(0, 32'h40000000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1);
    serve(50);
    drain(50);
    exp_gnt_q.push_back(2'd0);
    set_op(0, 32'h40000000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0, 1);
    serve(50);
    drain(50);

    // Approximate divide 4.2 / 3.2.
    exp_gnt_q.push_back(2'd2);
    set_op(2, 32'h40866666, 32'h404CCCCD, 32'h3FA80000, 1'b0, 1'b1, 1);
    serve(50);
    drain(50);

    // Backpressure: response held for 5 cycles.
    resp_ready = 1'b0;
    exp_gnt_q.push_back(2'd3);
    set_op(3, 32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 1);
    serve(50);
    k = 0;
    while (!resp_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_val("bp_valid", {31'd0, resp_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_val("bp_still_valid", {31'd0, resp_valid}, 32'd1);
    check_val("bp_count", {16'd0, op_count}, {16'd0, exp_count});
    resp_ready = 1'b1;
    drain(50);

    // Random exact and zero-divisor operations with random response stalls.
    for (int n = 0; n < 10; n++) begin
      v = $urandom_range(0, 4);
      k = $urandom_range(0, 3);
      resp_ready = 1'($urandom_range(0, 1));
      exp_gnt_q.push_back(2'(k));
      if (v == 4) begin
        a = $urandom;
        b = {1'($urandom_range(0, 1)), 31'd0};
        set_op(k, a, b, {a[31] ^ b[31], 8'hFF, 23'd0}, 1'b1, 1'b0, 1);
      end else begin
        set_op(k, vec_a[v], vec_b[v], vec_q[v], 1'b0, 1'b0, 1);
      end
      serve(50);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      resp_ready = 1'b1;
      drain(50);
    end

    // Asynchronous reset in the middle of WAIT.
    exp_gnt_q.push_back(2'd1);
    set_op(1, 32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 1);
    serve(50);
    @(posedge clk);
    #3;
    check_val("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_gnt_q.delete();
    exp_count = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_gnt_q.push_back(2'd0);
    exp_gnt_q.push_back(2'd2);
    set_op(2, 32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 1);
    set_op(0, 32'hC1100000, 32'h40400000, 32'hC0400000, 1'b0, 1'b0, 1);
    serve(100);
    drain(50);

    check_val("final_count", {16'd0, op_count}, {16'd0, exp_count});
    check_val("final_count_c2", {30'd0, op_count_c2}, {30'd0, exp_count[1:0]});
    check_val("final_gnt_left", exp_gnt_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_div_scheduler.md
Name: fpu_div_scheduler

Overview:
- Shares one combinational FloatingDivision datapath among NUM_REQ requesters using round-robin arbitration.
- The divider is treated as a multicycle path. Operands are registered and held stable for DIV_CYCLES clocks, then the result is captured into a response register.
- A divide-by-zero fast path bypasses the wait. The block sits between the FPU issue logic and the shared divider.

Parameters:
- XLEN, 32, operand/result width (IEEE-754 single).
- NUM_REQ, 4, number of requesters (>=2).
- DIV_CYCLES, 3, clocks operands are held before the result is sampled (>=1).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*XLEN  packed dividends; requester i at [i*XLEN +: XLEN].
- req_b  in  NUM_REQ*XLEN  packed divisors, same packing.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NUM_REQ)  index of the requester owning the response.
- resp_result  out  XLEN  quotient.
- resp_zero_div  out  1  divisor was +/-0.
- busy  out  1  state != IDLE.
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1):
  - State IDLE, rr pointer=0, wait counter=0.
  - resp_valid=0, resp_id=0, resp_result=0, resp_zero_div=0, op_count=0, req_ready=0.
  - Any in-flight operation is discarded.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Arbiter grants the first valid requester at or after rr pointer, wrapping.
  - req_ready[g]=1 combinationally only in IDLE, only for the granted g, and only when req_valid[g]=1.
  - Handshake (req_valid[g]&req_ready[g]) at edge t: latch req_a[g], req_b[g], id=g; rr pointer <= g+1 mod NUM_REQ.
  - Zero divisor (req_b[g][XLEN-2:0]==0): go to RESP at t+1 with result={a[31]^b[31],8'hFF,23'b0}, resp_zero_div=1.
  - Otherwise: go to WAIT, counter <= DIV_CYCLES-1.
- WAIT:
  - Operand registers drive the divider and are held stable.
  - Counter decrements each clock.
  - When counter==0: capture divider result and zero_division into the response registers; go to RESP.
  - resp_valid first asserts at t+DIV_CYCLES+1.
- RESP:
  - resp_valid=1; resp_* held stable until resp_valid&resp_ready.
  - On that handshake: op_count++ (wraps), go to IDLE.
  - No new acceptance in the handshake cycle; earliest next acceptance is the following cycle.
- No request is accepted while busy. req_ready is all-zero in WAIT/RESP.
- Requesters may drop req_valid before grant without effect.
- A requester not granted retains priority position; starvation-free.
- Input operands are not sampled after the handshake cycle; changes to req_a/req_b have no effect.
- NaN/Inf/denormal handling is whatever the divider produces. The only override is the zero-divisor fast path.

Decomposition:
- Package fpu_sched_pkg: state enum (IDLE, WAIT, RESP), XLEN default, constant for zero-divide infinity pattern (exp 8'hFF, mantissa 0), helper function is_zero(operand).
- Sub-module fpu_rr_arbiter:
  - Inputs: NUM_REQ requests, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The scheduler instantiates fpu_rr_arbiter and one FloatingDivision.

Test Plan:
- Basic divide, exact result:
  - Stimulus: requester 1 sends A=0x41000000 (8.0), B=0x40000000 (2.0) at cycle t, DIV_CYCLES=3, resp_ready=1.
  - Response: resp_valid at t+4; resp_id=1, resp_result=0x40800000, resp_zero_div=0; op_count=1 after handshake.
- Zero divisor:
  - Stimulus: requester 0 sends A=0x40000000, B=0x00000000.
  - Response: resp_valid at t+1, result=0x7F800000, zero_div=1.
  - Repeat with B=0x80000000: expect 0xFF800000.
- Round-robin fairness:
  - Stimulus: all four req_valid held high, resp_ready=1.
  - Response: grant order 0,1,2,3,0; exactly one req_ready bit per accept; no req_ready while busy.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid.
  - Response: resp_id/result/zero_div stable, req_ready=0 throughout, op_count unchanged until the handshake.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT, asynchronously mid-cycle.
  - Response: outputs zero immediately; after release, requesters 2 and 0 both valid, so requester 0 is granted first.
- Approximate divide and counter wrap:
  - Stimulus: 4.2/3.2 (0x40866666/0x404CCCCD); separately, force CNT_W=2 and run 5 ops.
  - Response: result within 1 ULP of 0x3FA80000; op_count sequence 1,2,3,0,1.
